// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus: source codes, select width, idle code and arbiter state type.
// Pure declarations; no timing or flow control of its own.
package bus_pkg;

  localparam int NUM_SRC  = 24;
  localparam int SEL_W    = 5;
  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 2;

  localparam logic [SEL_W-1:0] SEL_IDLE = 5'd31;

  localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
  localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
  localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
  localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
  localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
  localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
  localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
  localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
  localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
  localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
  localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
  localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
  localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
  localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
  localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
  localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
  localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Rotating-priority encoder: first set req bit at or above ptr, wrapping to 0.
// Purely combinational, zero latency, no flow control.
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter int N_SRC = NUM_SRC,
  parameter int W_SEL = SEL_W
) (
  input  logic [N_SRC-1:0] req,
  input  logic [W_SEL-1:0] ptr,
  output logic             any,
  output logic [W_SEL-1:0] idx
);

  localparam logic [W_SEL:0] N_SRC_W = (W_SEL+1)'(N_SRC);

  logic [W_SEL:0] cand;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (W_SEL+1)'(k);
      if (cand >= N_SRC_W) cand = cand - N_SRC_W;
      if (req[cand[W_SEL-1:0]]) begin
        any = 1'b1;
        idx = cand[W_SEL-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the CPU bus: registered select and one-hot grant, 1-cycle req->gnt, bounded lock.
// Optional BUS_ARB_PC_PRIORITY_EN: PC wins every arbitration (never pre-empts a live lock) without moving ptr.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_SRC  = NUM_SRC,
  parameter int W_SEL  = SEL_W,
  parameter int N_HOLD = MAX_HOLD
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_SRC-1:0]  req,
  input  logic              lock,
  output logic [W_SEL-1:0]  sel,
  output logic [N_SRC-1:0]  gnt,
  output logic              bus_valid,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [W_SEL-1:0]  IDLE_SEL  = '1;
  localparam logic [W_SEL-1:0]  LAST_SRC  = W_SEL'(N_SRC-1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(N_HOLD-1);

  arb_state_e        state_q, state_d;
  logic [W_SEL-1:0]  sel_q, sel_d;
  logic [N_SRC-1:0]  gnt_q, gnt_d;
  logic              bus_valid_q, bus_valid_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [W_SEL-1:0]  ptr_q, ptr_d;

  logic              pick_any;
  logic [W_SEL-1:0]  pick_idx;
  logic [W_SEL-1:0]  win;
  logic              new_grant;
  logic              keep;

  bus_rr_pick #(
    .N_SRC (N_SRC),
    .W_SEL (W_SEL)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    bus_valid_d = bus_valid_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    new_grant   = 1'b0;
    keep        = 1'b0;
    win         = pick_idx;

    if (state_q == ST_OWN) begin
      keep = req[sel_q] && lock && (hold_cnt_q < HOLD_LAST);
    end

    if (keep) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end else if (pick_any) begin
      new_grant = 1'b1;
    end else begin
      state_d     = ST_IDLE;
      sel_d       = IDLE_SEL;
      gnt_d       = '0;
      bus_valid_d = 1'b0;
      hold_cnt_d  = '0;
    end

    if (new_grant) begin
`ifdef BUS_ARB_PC_PRIORITY_EN
      if (req[SRC_PC]) begin
        win = SRC_PC;
      end else begin
        ptr_d = (pick_idx == LAST_SRC) ? '0 : pick_idx + 1'b1;
      end
`else
      ptr_d = (pick_idx == LAST_SRC) ? '0 : pick_idx + 1'b1;
`endif
      state_d        = ST_OWN;
      sel_d          = win;
      gnt_d          = '0;
      gnt_d[win]     = 1'b1;
      bus_valid_d    = 1'b1;
      hold_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      sel_q       <= IDLE_SEL;
      gnt_q       <= '0;
      bus_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      bus_valid_q <= bus_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign bus_valid = bus_valid_q;
  assign hold_cnt  = hold_cnt_q;

  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_q));
  a_gnt_matches_sel : assert property (@(posedge clk) bus_valid_q |-> gnt_q[sel_q]);
  a_sel_range : assert property (@(posedge clk) (sel_q < W_SEL'(N_SRC)) || (sel_q == IDLE_SEL));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single grant, wrap, lock bound, mid-lock reset, PC priority.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [23:0] req;
  logic        lock;
  logic [4:0]  sel;
  logic [23:0] gnt;
  logic        bus_valid;
  logic [1:0]  hold_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .lock      (lock),
    .sel       (sel),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .hold_cnt  (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr  = 1'b0;
    req  = '0;
    lock = 1'b0;
    tick();
    clr = 1'b1;
  endtask

  // Expected owner after each edge; also verifies grant and valid agree with it.
  task automatic chk_owner(input string tag, input int src, input int hc);
    logic [23:0] g;
    g = '0;
    g[src] = 1'b1;
    chk({tag, "_sel"}, 32'(sel), 32'(src));
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_vld"}, 32'(bus_valid), 32'd1);
    chk({tag, "_hc"}, 32'(hold_cnt), 32'(hc));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd31);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_vld"}, 32'(bus_valid), 32'd0);
    chk({tag, "_hc"}, 32'(hold_cnt), 32'd0);
  endtask

  int exp3 [5] = '{3, 7, 23, 3, 7};

  initial begin
    // 1: reset dominates all-ones requests
    clr  = 1'b0;
    req  = '1;
    lock = 1'b0;
    tick();
    tick();
    chk_idle("rst");

    // 2: single request, one-cycle latency, release on drop
    clr = 1'b1;
    req = 24'd1 << 5;
    tick();
    chk_owner("single", 5, 0);
    req = '0;
    tick();
    chk_idle("single_drop");

    // 3: round robin with wrap from 23 back to 3
    do_reset();
    req = (24'd1 << 3) | (24'd1 << 7) | (24'd1 << 23);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_owner($sformatf("rr%0d", i), exp3[i], 0);
    end

    // 4: lock bounded at four cycles, then outgoing owner yields
    do_reset();
    req  = (24'd1 << 2) | (24'd1 << 9);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_owner($sformatf("lock%0d", i), 2, i);
    end
    tick();
    chk_owner("lock_yield", 9, 0);
    tick();
    chk_owner("lock_next", 9, 1);

    // 5: reset mid-lock drops the grant, then re-grant from scratch
    do_reset();
    req  = 24'd1 << 4;
    lock = 1'b1;
    tick();
    chk_owner("ml0", 4, 0);
    tick();
    chk_owner("ml1", 4, 1);
    clr = 1'b0;
    tick();
    chk_idle("ml_rst");
    clr = 1'b1;
    tick();
    chk_owner("ml_regrant", 4, 0);

    // Sole requester re-wins after the hold limit with a fresh count
    tick();
    tick();
    tick();
    chk_owner("sole_hc3", 4, 3);
    tick();
    chk_owner("sole_rewin", 4, 0);

    // Owner dropping req releases despite lock
    req = '0;
    tick();
    chk_idle("drop_locked");

    // 6: PC vs R0
    do_reset();
    req  = (24'd1 << 0) | (24'd1 << 20);
    lock = 1'b0;
    tick();
`ifdef BUS_ARB_PC_PRIORITY_EN
    chk_owner("pc0", 20, 0);
    tick();
    chk_owner("pc1", 20, 0);
`else
    chk_owner("pc0", 0, 0);
    tick();
    chk_owner("pc1", 20, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
